spi_slave_mem: RTL and testbench
================================

// Module: spi_slave_mem
// PURPOSE
//  SPI-style slave with a 32x8 register memory; downstream of the SPI master.
//  Decodes 15-bit LSB-first command frames on MOSI, executes single writes and single/incremented reads.
//  Read data returns on MISO, a wired-OR bus; the slave drives 0 when deselected.
//  One instance hangs on each chip select (CS0/CS1); everything runs on the shared system clk.
// PARAMETERS
//  FRAME_GAP  3  idle cycles after header slot 14 before the first incremented byte slot
//  BYTE_GAP   2  idle cycles after each incremented byte before the next byte slot
//  DEPTH      32 memory words; fixed by the 5-bit address field; do not override
// PORTS
//  clk        in   1  system clock; all sampling and driving on posedge
//  rst        in   1  asynchronous, active-low reset
//  CS         in   1  chip select, active-low; high aborts any frame
//  MOSI       in   1  serial command/data from master, LSB first
//  MISO       out  1  serial read data; 0 whenever not actively returning a read bit
//  wr_strobe  out  1  1-cycle pulse when a memory write commits
//  rd_strobe  out  1  1-cycle pulse after each returned read byte completes
//  busy       out  1  high while state != IDLE
// BEHAVIOUR
//  Frame format, slot n = nth posedge with CS low, counted from 0:
//   [1:0] mode (bit1: 1=write, 0=read; bit0: 1=incremented read), [6:2] addr, [14:7] data/count.
//  Reset values: MISO=0, wr_strobe=0, rd_strobe=0, busy=0, state=IDLE, all counters 0, memory all 0x00.
//  FSM states: IDLE, HDR, GAP, INC, IGAP.
//   IDLE -> HDR: at the first posedge with CS low; slot 0 is sampled on that edge.
//   HDR: samples slots 0..14 into a 15-bit shift register.
//   HDR after slot 14:
//    - write: mem[addr] <= data; wr_strobe pulses the next cycle; state -> IDLE.
//    - single read: rd_strobe pulses; state -> IDLE.
//    - incremented read with count > 1 and addr != 31: state -> GAP.
//   GAP -> INC: after FRAME_GAP cycles.
//   INC: 8 slots. MISO = mem[ptr][k] in slot k. ptr starts at addr+1 and increments after each byte.
//   INC -> IGAP: after slot 7; rd_strobe pulses.
//   IGAP: lasts BYTE_GAP cycles, then -> INC, or -> IDLE when either condition holds:
//    - bytes returned == count (header byte included);
//    - ptr passed 31.
//  Read data in HDR: in slots 7..14, MISO = mem[addr][slot-7]. Combinational from registered mode/addr.
//   The write bit is zero during these slots.
//  Write with mode bit0=1: treated as a single write; the incremented path is never entered.
//  Incremented count: field [11:7] only (5 bits); count 0 or 1 = header byte only. Address never wraps.
//  Abort: CS high in any non-IDLE state -> IDLE on that edge. No write commits, no strobe, MISO=0 next cycle.
//  CS held low in IDLE after a completed frame: no new frame starts until CS has been high for at least 1 cycle.
//  Async reset mid-frame: immediate return to reset values. Memory contents are also cleared.
//  MISO is never driven X; it is 0 outside read slots so wired-OR sharing is safe.
// CONFIGURATION
//  SPI_SLAVE_WP_EN defined: adds input port wp (1 bit).
//   - wp=1 sampled at slot 14 suppresses the write: no memory update, no wr_strobe.
//   - reads are unaffected.
//  SPI_SLAVE_WP_EN undefined: no wp port; all writes commit.
// TESTING
//  Reset: rst low for 3 cycles with CS toggling -> MISO=0, busy=0, strobes 0; read of addr 5 returns 0x00.
//  Write 0xA5 to addr 3 (mode=2'b10), then single read of addr 3 (mode=2'b00):
//   -> wr_strobe pulses once; MISO returns bits 1,0,1,0,0,1,0,1 in slots 7..14.
//  Preload addr 28..31 = 0x11,0x22,0x33,0x44, then incremented read at addr 28, count 6:
//   -> bytes 0x11,0x22,0x33,0x44 returned; IDLE after the addr-31 byte; 4 rd_strobe pulses total.
//  Incremented read at addr 0, count 3 -> 3 bytes returned, with 3 gap cycles then 2 gap cycles; busy drops after the last IGAP.
//  CS raised at slot 10 of a write to addr 7 -> mem[7] unchanged, no wr_strobe, IDLE next cycle.
//  With SPI_SLAVE_WP_EN and wp=1: write 0xFF to addr 1 -> mem[1] unchanged, no wr_strobe; wp=0 repeat -> mem[1]=0xFF.

Source files
------------

// File: rtl/spi_slave_mem_if.sv
// Bus bundle between an SPI master and one spi_slave_mem instance.
// The wp member exists only when SPI_SLAVE_WP_EN is defined.
interface spi_slave_mem_if;
    logic cs;
    logic mosi;
    logic miso;
    logic wr_strobe;
    logic rd_strobe;
    logic busy;
`ifdef SPI_SLAVE_WP_EN
    logic wp;

    modport master (output cs, mosi, wp, input miso, wr_strobe, rd_strobe, busy);
    modport slave  (input cs, mosi, wp, output miso, wr_strobe, rd_strobe, busy);
`else
    modport master (output cs, mosi, input miso, wr_strobe, rd_strobe, busy);
    modport slave  (input cs, mosi, output miso, wr_strobe, rd_strobe, busy);
`endif
endinterface

// File: rtl/spi_slave_mem.sv
// SPI-style slave with a 32x8 register memory: decodes 15-bit LSB-first command frames and
// returns read data on a wired-OR MISO. Define SPI_SLAVE_WP_EN to add the write-protect input.
module spi_slave_mem #(
    parameter int unsigned FRAME_GAP = 3,
    parameter int unsigned BYTE_GAP  = 2
) (
    input logic            clk,
    input logic            rst,
    spi_slave_mem_if.slave bus
);
    localparam int unsigned DEPTH = 32;

    typedef enum logic [2:0] {StIdle, StHdr, StGap, StInc, StIgap} state_e;

    state_e      state_q, state_d;
    logic [13:0] sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [5:0]  nbytes_q, nbytes_d;
    logic        armed_q, armed_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic        rd_strobe_q, rd_strobe_d;
    logic [7:0]  mem_q [DEPTH];

    logic       cs_low;
    logic       last_slot;
    logic       hdr_inc;
    logic       gap_end;
    logic       byte_end;
    logic       igap_end;
    logic       run_done;
    logic       wp_block;
    logic       mem_we;
    logic [4:0] hdr_addr;
    logic [4:0] hdr_count;
    logic [7:0] hdr_data;

    assign cs_low    = !bus.cs;
    assign hdr_addr  = sr_q[6:2];
    assign hdr_count = sr_q[11:7];
    // Slot 14 is sampled on the committing edge, so the top data bit comes straight from MOSI.
    assign hdr_data  = {bus.mosi, sr_q[13:7]};
    assign last_slot = (state_q == StHdr) && cs_low && (cnt_q == 4'd14);
    assign hdr_inc   = !sr_q[1] && sr_q[0] && (hdr_count > 5'd1) && (hdr_addr != 5'd31);
    assign gap_end   = cnt_q == 4'(FRAME_GAP - 1);
    assign byte_end  = cnt_q == 4'd7;
    assign igap_end  = cnt_q == 4'(BYTE_GAP - 1);
    assign run_done  = (nbytes_q == {1'b0, hdr_count}) || ptr_q[5];
`ifdef SPI_SLAVE_WP_EN
    assign wp_block  = bus.wp;
`else
    assign wp_block  = 1'b0;
`endif
    assign mem_we    = last_slot && sr_q[1] && !wp_block;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != StIdle && !cs_low) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (cs_low && armed_q) state_d = StHdr;
                StHdr:   if (cnt_q == 4'd14) state_d = hdr_inc ? StGap : StIdle;
                StGap:   if (gap_end) state_d = StInc;
                StInc:   if (byte_end) state_d = StIgap;
                StIgap:  if (igap_end) state_d = run_done ? StIdle : StInc;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bus.busy = (state_q != StIdle);
        bus.miso = 1'b0;
        case (state_q)
            StHdr: begin
                if (cnt_q >= 4'd7 && !sr_q[1]) begin
                    bus.miso = mem_q[hdr_addr][3'(cnt_q - 4'd7)];
                end
            end
            StInc:   bus.miso = mem_q[ptr_q[4:0]][cnt_q[2:0]];
            default: bus.miso = 1'b0;
        endcase
    end

    assign bus.wr_strobe = wr_strobe_q;
    assign bus.rd_strobe = rd_strobe_q;

    // A new frame needs CS to have been seen high since the previous one started.
    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        nbytes_d    = nbytes_q;
        armed_d     = armed_q;
        wr_strobe_d = 1'b0;
        rd_strobe_d = 1'b0;
        if (!cs_low) begin
            armed_d = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (armed_q) begin
                        sr_d[0] = bus.mosi;
                        cnt_d   = 4'd1;
                        armed_d = 1'b0;
                    end
                end
                StHdr: begin
                    if (cnt_q == 4'd14) begin
                        cnt_d       = '0;
                        wr_strobe_d = mem_we;
                        rd_strobe_d = !sr_q[1];
                        ptr_d       = {1'b0, hdr_addr} + 6'd1;
                        nbytes_d    = 6'd1;
                    end else begin
                        sr_d[cnt_q] = bus.mosi;
                        cnt_d       = cnt_q + 4'd1;
                    end
                end
                StGap:  cnt_d = gap_end ? 4'd0 : cnt_q + 4'd1;
                StInc: begin
                    if (byte_end) begin
                        cnt_d       = '0;
                        rd_strobe_d = 1'b1;
                        ptr_d       = ptr_q + 6'd1;
                        nbytes_d    = nbytes_q + 6'd1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StIgap:  cnt_d = igap_end ? 4'd0 : cnt_q + 4'd1;
                default: cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            ptr_q       <= '0;
            nbytes_q    <= '0;
            armed_q     <= 1'b1;
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            nbytes_q    <= nbytes_d;
            armed_q     <= armed_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[hdr_addr] <= hdr_data;
        end
    end
endmodule

// File: tb/tb_spi_slave_mem.sv
// Self-checking bench for spi_slave_mem: directed and random frames checked cycle by cycle
// against an expected trace built from a behavioural memory model.
module tb_spi_slave_mem;
    localparam int FRAME_GAP = 3;
    localparam int BYTE_GAP  = 2;

    logic clk = 1'b0;
    logic rst;

    spi_slave_mem_if bus();

    spi_slave_mem #(
        .FRAME_GAP(FRAME_GAP),
        .BYTE_GAP (BYTE_GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] model_mem [32];
    // Expected outputs per cycle, packed as {miso, busy, wr_strobe, rd_strobe}.
    logic [3:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {bus.miso, bus.busy, bus.wr_strobe, bus.rd_strobe};
    endfunction

    function automatic logic [14:0] mk(input logic [1:0] mode, input logic [4:0] addr,
                                       input logic [7:0] data);
        return {data, addr, mode};
    endfunction

    // Cycle t is the clock period that ends with slot t.
    function automatic void build_trace(input logic [14:0] frame, input logic wp_v);
        logic       is_wr;
        logic       is_inc;
        logic [4:0] addr;
        logic [7:0] data;
        int         cnt;
        int         p;
        int         nb;
        is_wr  = frame[1];
        is_inc = frame[0];
        addr   = frame[6:2];
        data   = frame[14:7];
        cnt    = int'(frame[11:7]);
        exp_q.delete();
        exp_q.push_back(4'b0000);
        for (int t = 1; t < 15; t++) begin
            exp_q.push_back({(!is_wr && t >= 7) ? model_mem[addr][t-7] : 1'b0, 3'b100});
        end
        if (is_wr) begin
            if (!wp_v) model_mem[addr] = data;
            exp_q.push_back({2'b00, !wp_v, 1'b0});
        end else if (is_inc && cnt > 1 && addr != 5'd31) begin
            exp_q.push_back(4'b0101);
            for (int g = 1; g < FRAME_GAP; g++) exp_q.push_back(4'b0100);
            p  = int'(addr) + 1;
            nb = 1;
            while (nb < cnt && p <= 31) begin
                for (int k = 0; k < 8; k++) exp_q.push_back({model_mem[p][k], 3'b100});
                exp_q.push_back(4'b0101);
                for (int g = 1; g < BYTE_GAP; g++) exp_q.push_back(4'b0100);
                nb++;
                p++;
            end
            exp_q.push_back(4'b0000);
        end else begin
            exp_q.push_back(4'b0001);
        end
        // CS stays low after completion: no new frame may start.
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
    endfunction

    task automatic run_frame(input string tag, input logic [14:0] frame, input logic wp_v);
        logic [3:0] exp_v;
        build_trace(frame, wp_v);
        for (int t = 0; t < exp_q.size(); t++) begin
            @(negedge clk);
            exp_v = exp_q[t];
            check($sformatf("%s cyc%0d", tag, t), 32'(outs()), 32'(exp_v));
            bus.cs   = 1'b0;
            bus.mosi = (t < 15) ? frame[t] : 1'($urandom);
`ifdef SPI_SLAVE_WP_EN
            bus.wp   = wp_v;
`endif
        end
        @(negedge clk);
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [14:0] frame;
        logic [1:0]  mode;
        for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
`ifdef SPI_SLAVE_WP_EN
        bus.wp   = 1'b0;
`endif
        rst = 1'b0;

        // Reset held with CS toggling.
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("reset_outs", 32'(outs()), 32'h0);
            bus.cs   = t[0];
            bus.mosi = 1'($urandom);
        end
        @(negedge clk);
        rst    = 1'b1;
        bus.cs = 1'b1;
        @(negedge clk);
        run_frame("rd_after_reset", mk(2'b00, 5'd5, 8'h00), 1'b0);

        // Write 0xA5 to addr 3, read it back.
        run_frame("wr_a5", mk(2'b10, 5'd3, 8'hA5), 1'b0);
        run_frame("rd_a5", mk(2'b00, 5'd3, 8'h00), 1'b0);

        // Incremented read clipped at address 31.
        run_frame("pre28", mk(2'b10, 5'd28, 8'h11), 1'b0);
        run_frame("pre29", mk(2'b10, 5'd29, 8'h22), 1'b0);
        run_frame("pre30", mk(2'b10, 5'd30, 8'h33), 1'b0);
        run_frame("pre31", mk(2'b11, 5'd31, 8'h44), 1'b0);
        run_frame("inc28_c6", mk(2'b01, 5'd28, 8'd6), 1'b0);

        // Incremented read at 0 with count 3; also count 1 and addr 31 stay single.
        run_frame("pre0", mk(2'b10, 5'd0, 8'h5C), 1'b0);
        run_frame("pre1", mk(2'b10, 5'd1, 8'hE3), 1'b0);
        run_frame("pre2", mk(2'b10, 5'd2, 8'h96), 1'b0);
        run_frame("inc0_c3", mk(2'b01, 5'd0, 8'd3), 1'b0);
        run_frame("inc0_c1", mk(2'b01, 5'd0, 8'd1), 1'b0);
        run_frame("inc31_c5", mk(2'b01, 5'd31, 8'd5), 1'b0);
        run_frame("inc_hi_bits", mk(2'b01, 5'd10, 8'hE2), 1'b0);

        // Abort: CS raised at slot 10 of a write to addr 7.
        frame = mk(2'b10, 5'd7, 8'h3C);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            check($sformatf("abort cyc%0d", t), 32'(outs()),
                  (t >= 1 && t <= 10) ? 32'h4 : 32'h0);
            bus.cs   = (t >= 10);
            bus.mosi = frame[t];
        end
        run_frame("rd7_after_abort", mk(2'b00, 5'd7, 8'h00), 1'b0);

`ifdef SPI_SLAVE_WP_EN
        run_frame("wp_wr", mk(2'b10, 5'd1, 8'hFF), 1'b1);
        run_frame("wp_rd", mk(2'b00, 5'd1, 8'h00), 1'b0);
        run_frame("nowp_wr", mk(2'b10, 5'd1, 8'hFF), 1'b0);
        run_frame("nowp_rd", mk(2'b00, 5'd1, 8'h00), 1'b1);
`endif

        // Random frames.
        for (int n = 0; n < 24; n++) begin
            mode  = 2'($urandom_range(0, 3));
            frame = mk(mode, 5'($urandom), 8'($urandom));
            run_frame($sformatf("rand%0d", n), frame, 1'b0);
        end

        // Asynchronous reset mid-frame clears state and memory.
        run_frame("pre9", mk(2'b10, 5'd9, 8'h5A), 1'b0);
        frame = mk(2'b00, 5'd9, 8'h00);
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            bus.cs   = 1'b0;
            bus.mosi = frame[t];
        end
        #2 rst = 1'b0;
        #1 check("async_reset_outs", 32'(outs()), 32'h0);
        for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
        @(negedge clk);
        bus.cs = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        run_frame("rd9_after_reset", mk(2'b00, 5'd9, 8'h00), 1'b0);
        run_frame("inc28_after_reset", mk(2'b01, 5'd28, 8'd4), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
